ice40_sb_io_model: RTL and testbench
====================================

// Module: ice40_sb_io_model
// PURPOSE
//  Behavioural, synthesizable model of one iCE40 SB_IO pad cell for simulating the DVI
//  top level: DDR TMDS data pins and the direct-output TMDS clock pin.
//  Sits between core logic (dvi serializer, pixel clock) and the package pin.
//  Used for simulation in place of the vendor cell; no PLL or global-buffer function.
// PARAMETERS
//  PIN_TYPE     6'b010010  [5:4] output enable, [3:2] output data path, [1:0] input path
//  NEG_TRIGGER  1'b0       1: every register uses the inverted OUTPUT_CLK
//  PULLUP       1'b0       1: pad reads 1 when the output is hi-Z and nothing else drives it
// PORTS
//  OUTPUT_CLK         in     1  single clock for all pad registers (input and output)
//  i_rst              in     1  asynchronous, active-high reset
//  CLOCK_ENABLE       in     1  register clock enable, active high
//  D_OUT_0            in     1  output data (rising-edge half in DDR mode)
//  D_OUT_1            in     1  output data (falling-edge half in DDR mode)
//  OUTPUT_ENABLE      in     1  tristate control for PIN_TYPE[5] = 1
//  LATCH_INPUT_VALUE  in     1  1 holds D_IN_0 in latch input modes
//  PACKAGE_PIN        inout  1  pad
//  D_IN_0             out    1  pad sampled on the rising edge, or direct
//  D_IN_1             out    1  pad sampled on the falling edge
// BEHAVIOUR
//  - Reset: clock = OUTPUT_CLK ^ NEG_TRIGGER; i_rst clears every register to 0 at once.
//    While i_rst is high: D_IN_0 = D_IN_1 = 0 and registered outputs drive 0.
//  - CE = CLOCK_ENABLE. CE = 0 holds every register (pos and neg edge).
//  - Output enable, PIN_TYPE[5:4]:
//    00 = pin hi-Z; 01 = always driven;
//    10 = driven when OUTPUT_ENABLE = 1 (combinational);
//    11 = driven when a posedge-registered copy of OUTPUT_ENABLE = 1.
//  - Output data, PIN_TYPE[3:2]:
//    * 00 DDR: q0 <= D_OUT_0 on posedge, q1 <= D_OUT_1 on negedge.
//      Pin = clock ? q0 : q1, so the pad toggles at twice the clock rate.
//      Latency: D_OUT_0 appears 0 cycles after the capturing posedge;
//      D_OUT_1 appears at the following negedge.
//    * 01 registered: pin = q0, one posedge of latency.
//    * 10 direct: pin = D_OUT_0, combinational (clock not used); unaffected by i_rst/CE.
//    * 11 registered inverted: pin = ~q0.
//  - Input path, PIN_TYPE[1:0]; pad read = PACKAGE_PIN, resolved to 1 by PULLUP if Z,
//    otherwise X passes through:
//    * [0] = 0: D_IN_0 = posedge register of pad.
//    * [0] = 1: D_IN_0 = pad directly.
//    * [1] = 1 (latch mode): while LATCH_INPUT_VALUE = 1, D_IN_0 holds its last value.
//    * D_IN_1: negedge register of pad, in all modes.
//  - When the output is enabled, the input path reads back the driven value.
//  - Simultaneous reset and edge: reset wins.
//  - Reset deassertion mid-clock: the first capture happens at the next active edge.
//  - The p/n pair is two instances, the n instance with inverted data; no coupling is
//    modelled.
// TESTING
//  - PIN_TYPE 010010, CE = 1, D_OUT_0 = 1, D_OUT_1 = 0 held -> pin = 1 while clk high,
//    0 while clk low.
//  - DDR with D_OUT_0/D_OUT_1 = 10-bit TMDS pattern 0x1F0 split fe/re per cycle -> pin
//    sequence matches, 2 bits per clock.
//  - PIN_TYPE 011010, D_OUT_0 = pixel clock -> pin follows it combinationally;
//    i_rst = 1 does not affect it.
//  - i_rst pulse mid-stream in DDR mode -> pin = 0 at once and stays 0;
//    the first new data appears after the first posedge after release.
//  - CE = 0 for 3 cycles in registered mode (010110) -> pin holds its value;
//    it resumes with 1-cycle latency.
//  - PIN_TYPE 000001, PULLUP = 1, pin undriven -> D_IN_0 = 1; external drive 0 -> D_IN_0 = 0
//    directly; D_IN_1 updates at the negedge.

Source files
------------

// File: rtl/ice40_sb_io_model.sv
// Behavioural model of one iCE40 SB_IO pad cell: DDR/registered/direct output paths,
// tristate control and registered/direct/latched input paths with optional pull-up.
module ice40_sb_io_model #(
  parameter logic [5:0] PIN_TYPE    = 6'b010010,
  parameter logic       NEG_TRIGGER = 1'b0,
  parameter logic       PULLUP      = 1'b0
) (
  input  logic OUTPUT_CLK,
  input  logic i_rst,
  input  logic CLOCK_ENABLE,
  input  logic D_OUT_0,
  input  logic D_OUT_1,
  input  logic OUTPUT_ENABLE,
  input  logic LATCH_INPUT_VALUE,
  inout  wire  PACKAGE_PIN,
  output logic D_IN_0,
  output logic D_IN_1
);

  localparam logic [1:0] OeMode    = PIN_TYPE[5:4];
  localparam logic [1:0] OutMode   = PIN_TYPE[3:2];
  localparam logic       InDirect  = PIN_TYPE[0];
  localparam logic       InLatch   = PIN_TYPE[1];

  logic pad_clk;
  logic q0_q, q1_q, oe_q, din0_q, din1_q;
  logic out_val, out_en, pad_in, hold;

  assign pad_clk = OUTPUT_CLK ^ NEG_TRIGGER;
  assign hold    = InLatch && LATCH_INPUT_VALUE;

  always_ff @(posedge pad_clk or posedge i_rst) begin
    if (i_rst) begin
      q0_q   <= 1'b0;
      oe_q   <= 1'b0;
      din0_q <= 1'b0;
    end else if (CLOCK_ENABLE) begin
      q0_q <= D_OUT_0;
      oe_q <= OUTPUT_ENABLE;
      if (!hold) begin
        din0_q <= pad_in;
      end
    end
  end

  always_ff @(negedge pad_clk or posedge i_rst) begin
    if (i_rst) begin
      q1_q   <= 1'b0;
      din1_q <= 1'b0;
    end else if (CLOCK_ENABLE) begin
      q1_q   <= D_OUT_1;
      din1_q <= pad_in;
    end
  end

  always_comb begin
    out_val = 1'b0;
    case (OutMode)
      2'b00:   out_val = pad_clk ? q0_q : q1_q;
      2'b01:   out_val = q0_q;
      2'b10:   out_val = D_OUT_0;
      default: out_val = ~q0_q;
    endcase
    // Only the direct path bypasses reset; every registered path drives 0 in reset.
    if (i_rst && (OutMode != 2'b10)) begin
      out_val = 1'b0;
    end
  end

  always_comb begin
    out_en = 1'b0;
    case (OeMode)
      2'b00:   out_en = 1'b0;
      2'b01:   out_en = 1'b1;
      2'b10:   out_en = OUTPUT_ENABLE;
      default: out_en = oe_q;
    endcase
  end

  assign PACKAGE_PIN = out_en ? out_val : 1'bz;

  if (PULLUP) begin : g_pullup
    pullup (PACKAGE_PIN);
  end

  // Read back the driven value internally so the input path never sees contention.
  assign pad_in = out_en ? out_val : PACKAGE_PIN;

  always_comb begin
    D_IN_0 = din0_q;
    if (InDirect) begin
      D_IN_0 = hold ? din0_q : pad_in;
    end
    if (i_rst) begin
      D_IN_0 = 1'b0;
    end
  end

  assign D_IN_1 = din1_q;

endmodule

// File: tb/tb_ice40_sb_io_model.sv
// Directed bench for ice40_sb_io_model: DDR, direct, registered/CE and pull-up input cases.
module tb_ice40_sb_io_model;

  logic clk = 1'b0;
  logic rst;
  logic ce_ddr, ce_reg;
  logic d0_ddr, d1_ddr, d0_dir, d0_reg;
  logic ext_en, ext_val;

  wire  pin_ddr, pin_dir, pin_reg, pin_in;
  logic din0_ddr, din1_ddr, din0_dir, din1_dir, din0_reg, din1_reg, din0_in, din1_in;

  int checks   = 0;
  int failures = 0;

  logic [9:0] tmds = 10'h1F0;

  always #5 clk = ~clk;

  assign pin_in = ext_en ? ext_val : 1'bz;

  ice40_sb_io_model #(.PIN_TYPE(6'b010010), .NEG_TRIGGER(1'b0), .PULLUP(1'b0)) u_ddr (
    .OUTPUT_CLK(clk), .i_rst(rst), .CLOCK_ENABLE(ce_ddr), .D_OUT_0(d0_ddr), .D_OUT_1(d1_ddr),
    .OUTPUT_ENABLE(1'b1), .LATCH_INPUT_VALUE(1'b0), .PACKAGE_PIN(pin_ddr),
    .D_IN_0(din0_ddr), .D_IN_1(din1_ddr)
  );

  ice40_sb_io_model #(.PIN_TYPE(6'b011010), .NEG_TRIGGER(1'b0), .PULLUP(1'b0)) u_dir (
    .OUTPUT_CLK(clk), .i_rst(rst), .CLOCK_ENABLE(1'b1), .D_OUT_0(d0_dir), .D_OUT_1(1'b0),
    .OUTPUT_ENABLE(1'b1), .LATCH_INPUT_VALUE(1'b0), .PACKAGE_PIN(pin_dir),
    .D_IN_0(din0_dir), .D_IN_1(din1_dir)
  );

  ice40_sb_io_model #(.PIN_TYPE(6'b010110), .NEG_TRIGGER(1'b0), .PULLUP(1'b0)) u_reg (
    .OUTPUT_CLK(clk), .i_rst(rst), .CLOCK_ENABLE(ce_reg), .D_OUT_0(d0_reg), .D_OUT_1(1'b0),
    .OUTPUT_ENABLE(1'b1), .LATCH_INPUT_VALUE(1'b0), .PACKAGE_PIN(pin_reg),
    .D_IN_0(din0_reg), .D_IN_1(din1_reg)
  );

  ice40_sb_io_model #(.PIN_TYPE(6'b000001), .NEG_TRIGGER(1'b0), .PULLUP(1'b1)) u_in (
    .OUTPUT_CLK(clk), .i_rst(rst), .CLOCK_ENABLE(1'b1), .D_OUT_0(1'b0), .D_OUT_1(1'b0),
    .OUTPUT_ENABLE(1'b0), .LATCH_INPUT_VALUE(1'b0), .PACKAGE_PIN(pin_in),
    .D_IN_0(din0_in), .D_IN_1(din1_in)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    rst = 1'b1; ce_ddr = 1'b1; ce_reg = 1'b1;
    d0_ddr = 1'b0; d1_ddr = 1'b0; d0_dir = 1'b0; d0_reg = 1'b0;
    ext_en = 1'b0; ext_val = 1'b0;

    // Reset state, both clock phases.
    #2;
    check("rst_din0", din0_ddr, 1'b0);
    check("rst_din1", din1_ddr, 1'b0);
    check("rst_pin_lo", pin_ddr, 1'b0);
    @(posedge clk); #2;
    check("rst_pin_hi", pin_ddr, 1'b0);
    check("rst_pin_reg", pin_reg, 1'b0);
    check("rst_din0_in", din0_in, 1'b0);
    @(negedge clk); #3;
    rst = 1'b0;

    // Held DDR data: pin mirrors the clock phase.
    d0_ddr = 1'b1; d1_ddr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check("hold_hi", pin_ddr, 1'b1);
      @(negedge clk); #2;
      check("hold_lo", pin_ddr, 1'b0);
    end

    // TMDS word, LSB first: even bit on the rising half, odd bit on the falling half.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      d0_ddr = tmds[2*i]; d1_ddr = tmds[2*i+1];
      @(posedge clk); #2;
      check("tmds_re", pin_ddr, tmds[2*i]);
      @(negedge clk); #2;
      check("tmds_fe", pin_ddr, tmds[2*i+1]);
    end

    // Reset pulse mid-stream.
    d0_ddr = 1'b1; d1_ddr = 1'b1;
    @(posedge clk); #2;
    check("pre_rst", pin_ddr, 1'b1);
    #1 rst = 1'b1;
    #1 check("rst_now", pin_ddr, 1'b0);
    @(negedge clk); #2;
    check("rst_low", pin_ddr, 1'b0);
    #1 rst = 1'b0;
    #1 check("rel_low", pin_ddr, 1'b0);
    @(posedge clk); #2;
    check("rel_first", pin_ddr, 1'b1);

    // Direct output follows D_OUT_0 combinationally, regardless of reset.
    d0_dir = 1'b1; #1 check("dir_1", pin_dir, 1'b1);
    d0_dir = 1'b0; #1 check("dir_0", pin_dir, 1'b0);
    rst = 1'b1;
    d0_dir = 1'b1; #1 check("dir_rst_1", pin_dir, 1'b1);
    d0_dir = 1'b0; #1 check("dir_rst_0", pin_dir, 1'b0);
    rst = 1'b0;

    // Registered output with CE stall.
    @(posedge clk); #1 d0_reg = 1'b1;
    @(posedge clk); #2 check("reg_1", pin_reg, 1'b1);
    #1 ce_reg = 1'b0; d0_reg = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2 check("ce_hold", pin_reg, 1'b1);
    end
    #1 ce_reg = 1'b1;
    #1 check("ce_pre", pin_reg, 1'b1);
    @(posedge clk); #2 check("ce_resume", pin_reg, 1'b0);

    // Pull-up input, direct D_IN_0, negedge D_IN_1.
    @(negedge clk); #2;
    check("pu_din0", din0_in, 1'b1);
    check("pu_din1", din1_in, 1'b1);
    @(posedge clk); #1;
    ext_en = 1'b1; ext_val = 1'b0;
    #1 check("ext_din0", din0_in, 1'b0);
    check("ext_din1_hold", din1_in, 1'b1);
    @(negedge clk); #2;
    check("ext_din1", din1_in, 1'b0);
    ext_val = 1'b1;
    #1 check("ext_din0_1", din0_in, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
